// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM states, frame constants and
// bit-period helpers.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam logic        RX_IDLE   = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  // Bit period in clocks, rounded to nearest.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return (clk_hz + (baud / 2)) / baud;
  endfunction

  function automatic int unsigned calc_half(input int unsigned clk_hz,
                                            input int unsigned baud);
    return calc_div(clk_hz, baud) / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchronizer for a single asynchronous bit; both stages load
// RESET_VAL while rst_ni is low.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver, LSB first. Define UART_FRAMING_CHECK_EN to add the
// frame_err output and suppress data updates / rearm on a bad stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 busy,
  output logic [DATA_BITS-1:0] data
`ifdef UART_FRAMING_CHECK_EN
  ,
  output logic                 frame_err
`endif
);

  localparam int unsigned DIV   = calc_div(CLK_HZ, BAUD);
  localparam int unsigned HALF  = calc_half(CLK_HZ, BAUD);
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BIT_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic                 rxs;
  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 busy_q, busy_d;
  logic                 arm_c;

  sync_2ff #(
    .RESET_VAL(RX_IDLE)
  ) u_rx_sync (
    .clk_i (clk),
    .rst_ni(rst),
    .d_i   (rx),
    .q_o   (rxs)
  );

`ifdef UART_FRAMING_CHECK_EN
  logic ferr_q, ferr_d;
  logic wait_q, wait_d;

  // After a bad stop bit the line must return high before a new start counts.
  assign arm_c = ~wait_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ferr_q <= 1'b0;
      wait_q <= 1'b0;
    end else begin
      ferr_q <= ferr_d;
      wait_q <= wait_d;
    end
  end

  assign frame_err = ferr_q;
`else
  assign arm_c = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; every sample point is the last cycle of its count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    busy_d  = busy_q;
`ifdef UART_FRAMING_CHECK_EN
    ferr_d  = ferr_q;
    wait_d  = wait_q;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rxs != RX_IDLE && arm_c) begin
          state_d = START;
          busy_d  = 1'b1;
        end
`ifdef UART_FRAMING_CHECK_EN
        if (rxs == RX_IDLE) wait_d = 1'b0;
`endif
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          bit_d = '0;
          if (rxs == RX_IDLE) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[DATA_BITS-1:1]};
          if (bit_q == BIT_LAST) state_d = STOP;
          else                   bit_d   = bit_q + BIT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          busy_d  = 1'b0;
`ifdef UART_FRAMING_CHECK_EN
          ferr_d = ~rxs;
          if (rxs == RX_IDLE) data_d = shift_q;
          else                wait_d = 1'b1;
`else
          data_d = shift_q;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy = busy_q;
  assign data = data_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLK_HZ=16, BAUD=1 (16 clocks per bit); the
// framing-error scenario is built only with UART_FRAMING_CHECK_EN.
module tb_uart_rx;

  localparam int DIV  = 16;
  localparam int HALF = 8;
  localparam int FRAME_BUSY = HALF + 9 * DIV;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       busy;
  logic [7:0] data;
  logic       fe_w;

  int checks   = 0;
  int failures = 0;

  uart_rx #(
    .CLK_HZ(16),
    .BAUD  (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .busy     (busy),
    .data     (data)
`ifdef UART_FRAMING_CHECK_EN
    ,
    .frame_err(fe_w)
`endif
  );

`ifndef UART_FRAMING_CHECK_EN
  assign fe_w = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every busy falling edge with its high time and the data seen then.
  typedef struct {
    int         len;
    logic [7:0] d;
    logic       fe;
  } ev_t;

  ev_t ev_q[$];
  int  busy_len  = 0;
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      busy_len  = 0;
      busy_prev = 1'b0;
    end else begin
      if (busy) begin
        busy_len++;
      end else begin
        if (busy_prev) ev_q.push_back('{len: busy_len, d: data, fe: fe_w});
        busy_len = 0;
      end
      busy_prev = busy;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_event(input string name, input logic [7:0] exp_d,
                             input int exp_len, input logic exp_fe);
    ev_t e;
    check({name, "_count"}, 32'(ev_q.size()), 32'd1);
    if (ev_q.size() > 0) begin
      e = ev_q.pop_front();
      check({name, "_data"}, 32'(e.d), 32'(exp_d));
      check({name, "_len"}, 32'(e.len), 32'(exp_len));
`ifdef UART_FRAMING_CHECK_EN
      check({name, "_ferr"}, 32'(e.fe), 32'(exp_fe));
`endif
    end else begin
      checks++;
      failures++;
      $display("FAIL %s_missing: got no busy fall expected data %0h", name, exp_d);
    end
    ev_q.delete();
  endtask

  // Drive one 10-bit frame; starts and ends 1 time unit after a rising edge.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (DIV) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] byte_v;
    int         gap;
    logic [7:0] exp_d;
    int         exp_len;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int bad_busy;
    int bad_data;

    vecs[0] = '{byte_v: 8'hA5, gap: 20, exp_d: 8'hA5, exp_len: FRAME_BUSY};
    vecs[1] = '{byte_v: 8'h00, gap: 0,  exp_d: 8'h00, exp_len: FRAME_BUSY};
    vecs[2] = '{byte_v: 8'hFF, gap: 0,  exp_d: 8'hFF, exp_len: FRAME_BUSY};
    vecs[3] = '{byte_v: 8'h3C, gap: 20, exp_d: 8'h3C, exp_len: FRAME_BUSY};

    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_data", 32'(data), 32'd0);
    rst = 1'b1;

    bad_busy = 0;
    bad_data = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) bad_busy++;
      if (data !== 8'h00) bad_data++;
    end
    check("idle_busy_cycles", 32'(bad_busy), 32'd0);
    check("idle_data_cycles", 32'(bad_data), 32'd0);
    @(posedge clk);
    #1;
    ev_q.delete();

    for (int v = 0; v < 4; v++) begin
      send_frame(vecs[v].byte_v, 1'b1);
      check_event($sformatf("frame%0d", v), vecs[v].exp_d, vecs[v].exp_len, 1'b0);
      if (vecs[v].gap > 0) idle(vecs[v].gap);
    end

    // Glitch: 4 low clocks, busy rises 3 clocks after rx falls, lasts HALF.
    rx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rise_before", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("rise_at3", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    rx = 1'b1;
    idle(30);
    check_event("glitch", 8'h3C, HALF, 1'b0);

    // Reset in the middle of a frame (in DATA state).
    rx = 1'b0;
    repeat (40) @(posedge clk);
    #3;
    check("mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_data", 32'(data), 32'd0);
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(10);
    ev_q.delete();
    send_frame(8'h5A, 1'b1);
    check_event("after_rst", 8'h5A, FRAME_BUSY, 1'b0);
    idle(20);

`ifdef UART_FRAMING_CHECK_EN
    send_frame(8'h12, 1'b0);
    check_event("bad_stop", 8'h5A, FRAME_BUSY, 1'b1);
    check("bad_stop_ferr_level", 32'(fe_w), 32'd1);
    rx = 1'b0;
    bad_busy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) bad_busy++;
    end
    check("break_no_start", 32'(bad_busy), 32'd0);
    @(posedge clk);
    #1;
    idle(16);
    ev_q.delete();
    send_frame(8'h34, 1'b1);
    check_event("good_after_bad", 8'h34, FRAME_BUSY, 1'b0);
    check("good_ferr_level", 32'(fe_w), 32'd0);
    idle(10);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
